// File: rtl/addsub_serial_if.sv
// Operand/result bundle for addsub_serial.
// Both sides use strict valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holds valid (and its data)
// until that edge, and ready never depends combinationally on valid.
interface addsub_serial_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
   logic             z;

   modport master (
      output in_valid, a, b, ci, mode, out_ready,
      input  in_ready, out_valid, s, co, ovf, z
   );

   modport slave (
      input  in_valid, a, b, ci, mode, out_ready,
      output in_ready, out_valid, s, co, ovf, z
   );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// carry/borrow chained through r_chain. Result fields are registered on the
// edge entering DONE and hold until the next DONE entry or reset.
// o_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   addsub_serial_if.slave bus,
   output logic [1:0]     o_state
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_in_ready;
   logic             w_out_valid;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_chain;
   logic             r_mode;
   logic             r_a_msb;
   logic             r_b_msb;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] r_s;
   logic             r_co;
   logic             r_ovf;
   logic             r_z;

   logic [CHUNK:0]   w_ext_a;
   logic [CHUNK:0]   w_ext_bc;
   logic [CHUNK:0]   w_sum;
   logic [CHUNK-1:0] w_r;
   logic             w_c;
   logic [WIDTH-1:0] w_res_next;
   logic             w_s_msb;
   logic             w_ovf;
   logic             w_accept;
   logic             w_last;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

   // Operand chunk widened by one bit so the borrow compare sees b_k + chain.
   assign w_ext_a  = {1'b0, r_a[CHUNK-1:0]};
   assign w_ext_bc = {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_chain};

   // One chunk of add or subtract; c is the carry (add) or borrow (sub) out.
   always_comb begin
      w_sum = '0;
      w_c   = 1'b0;
      if (r_mode) begin
         w_sum = w_ext_a - w_ext_bc;
         w_c   = (w_ext_a < w_ext_bc);
      end else begin
         w_sum = w_ext_a + w_ext_bc;
         w_c   = w_sum[CHUNK];
      end
   end

   assign w_r = w_sum[CHUNK-1:0];

   // New chunk enters at the top; after NCHUNK cycles the LSB chunk sits at
   // bit 0. The shift form also covers CHUNK == WIDTH (r_res >> WIDTH = 0).
   assign w_res_next = (WIDTH'(w_r) << (WIDTH - CHUNK)) | (r_res >> CHUNK);

   // Overflow uses the sign bits captured at acceptance, since the operand
   // registers have been shifted away by the time the result is complete.
   assign w_s_msb = w_res_next[WIDTH-1];
   assign w_ovf   = r_mode ? ((r_a_msb != r_b_msb) && (w_s_msb != r_a_msb))
                           : ((r_a_msb == r_b_msb) && (w_s_msb != r_a_msb));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_next = RUN;
         end
         RUN: begin
            if (r_cnt == LAST_CNT) w_state_next = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Working registers: capture operands on acceptance, shift during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_chain <= 1'b0;
         r_mode  <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_chain <= bus.ci;
         r_mode  <= bus.mode;
         r_a_msb <= bus.a[WIDTH-1];
         r_b_msb <= bus.b[WIDTH-1];
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> CHUNK;
         r_b     <= r_b >> CHUNK;
         r_res   <= w_res_next;
         r_chain <= w_c;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Result fields load only on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s   <= '0;
         r_co  <= 1'b0;
         r_ovf <= 1'b0;
         r_z   <= 1'b0;
      end else if (w_last) begin
         r_s   <= w_res_next;
         r_co  <= w_c;
         r_ovf <= w_ovf;
         r_z   <= (w_res_next == '0);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.s         = r_s;
   assign bus.co        = r_co;
   assign bus.ovf       = r_ovf;
   assign bus.z         = r_z;
   assign o_state       = r_state;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed checks of addsub_serial (WIDTH=16, CHUNK=4) plus a sweep over
// CHUNK=1/4/16 at WIDTH=16 and WIDTH=8/CHUNK=2 against a word-level model.
module tb_addsub_serial;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   addsub_serial_if #(.WIDTH(16)) bus ();
   addsub_serial_if #(.WIDTH(16)) bus_c1 ();
   addsub_serial_if #(.WIDTH(16)) bus_c16 ();
   addsub_serial_if #(.WIDTH(8))  bus_w8 ();

   logic [1:0] st;
   logic [1:0] st_c1;
   logic [1:0] st_c16;
   logic [1:0] st_w8;

   addsub_serial #(.WIDTH(16), .CHUNK(4))  u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave),     .o_state(st));
   addsub_serial #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst_n(rst_n), .bus(bus_c1.slave),  .o_state(st_c1));
   addsub_serial #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst_n(rst_n), .bus(bus_c16.slave), .o_state(st_c16));
   addsub_serial #(.WIDTH(8),  .CHUNK(2))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(bus_w8.slave),  .o_state(st_w8));

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Word-level reference for one operation.
   task automatic ref_model(input int w, input logic [15:0] ia, ib, input logic ici, imode,
                            output logic [15:0] es, output logic eco, eovf, ez);
      logic [15:0] mask;
      logic [15:0] am;
      logic [15:0] bm;
      logic [16:0] full;
      logic        sa;
      logic        sb;
      logic        ss;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      am = ia & mask;
      bm = ib & mask;
      if (imode) begin
         full = {1'b0, am} - {1'b0, bm} - {16'd0, ici};
         eco  = ({1'b0, am} < ({1'b0, bm} + {16'd0, ici}));
      end else begin
         full = {1'b0, am} + {1'b0, bm} + {16'd0, ici};
         eco  = full[w];
      end
      es   = full[15:0] & mask;
      sa   = am[w-1];
      sb   = bm[w-1];
      ss   = es[w-1];
      eovf = imode ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      ez   = (es == 16'h0000);
   endtask

   // Driver: wait (bounded) for in_ready, present one operand set for one accepting edge.
   task automatic start_op(input logic [15:0] ia, ib, input logic ici, imode);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready: in_ready=%b expected 1", bus.in_ready);
      end
      bus.a = ia; bus.b = ib; bus.ci = ici; bus.mode = imode; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts edges after acceptance until out_valid (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Consume the result with a one-cycle out_ready pulse.
   task automatic finish_op();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.s !== 16'h0000)     begin errors++; $display("FAIL rst_s: got %h expected 0000", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      checks++; if (st !== 2'd0)            begin errors++; $display("FAIL rst_state: got %0d expected 0", st); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_subtract();
      int lat;
      start_op(16'h1234, 16'h0235, 1'b0, 1'b1);
      checks++; if (st !== 2'd1) begin errors++; $display("FAIL t1_run_state: got %0d expected 1", st); end
      wait_done(lat);
      checks++; if (lat !== 4)             begin errors++; $display("FAIL t1_latency: got %0d expected 4", lat); end
      checks++; if (bus.s !== 16'h0FFF)    begin errors++; $display("FAIL t1_s: got %h expected 0fff", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t1_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL t1_done_ready: got %b expected 0", bus.in_ready); end
      checks++; if (st !== 2'd2)           begin errors++; $display("FAIL t1_done_state: got %0d expected 2", st); end
      finish_op();
      checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL t1_after_hs: got %b expected 10", {bus.in_ready, bus.out_valid}); end
      checks++; if (bus.s !== 16'h0FFF)    begin errors++; $display("FAIL t1_s_held: got %h expected 0fff", bus.s); end
   endtask

   task automatic test_underflow();
      int lat;
      start_op(16'h0000, 16'h0001, 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (bus.s !== 16'hFFFF) begin errors++; $display("FAIL t2a_s: got %h expected ffff", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b100) begin errors++; $display("FAIL t2a_flags: got %b expected 100", {bus.co, bus.ovf, bus.z}); end
      finish_op();
      start_op(16'h0005, 16'h0005, 1'b1, 1'b1);
      wait_done(lat);
      checks++; if (bus.s !== 16'hFFFF) begin errors++; $display("FAIL t2b_s: got %h expected ffff", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b100) begin errors++; $display("FAIL t2b_flags: got %b expected 100", {bus.co, bus.ovf, bus.z}); end
      finish_op();
   endtask

   task automatic test_overflow();
      int lat;
      start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_done(lat);
      checks++; if (bus.s !== 16'h8000) begin errors++; $display("FAIL t3a_s: got %h expected 8000", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b010) begin errors++; $display("FAIL t3a_flags: got %b expected 010", {bus.co, bus.ovf, bus.z}); end
      finish_op();
      start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (bus.s !== 16'h7FFF) begin errors++; $display("FAIL t3b_s: got %h expected 7fff", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b010) begin errors++; $display("FAIL t3b_flags: got %b expected 010", {bus.co, bus.ovf, bus.z}); end
      finish_op();
   endtask

   task automatic test_carry_wrap();
      int lat;
      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(lat);
      checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL t4a_s: got %h expected 0000", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b101) begin errors++; $display("FAIL t4a_flags: got %b expected 101", {bus.co, bus.ovf, bus.z}); end
      finish_op();
      start_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
      wait_done(lat);
      checks++; if (bus.s !== 16'h0100) begin errors++; $display("FAIL t4b_s: got %h expected 0100", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t4b_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      finish_op();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      wait_done(lat);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a        = 16'hAAAA ^ 16'(i);
         bus.b        = 16'h5555;
         bus.mode     = 1'b1;
         @(posedge clk); #1;
         checks++; if (bus.s !== 16'h3333) begin errors++; $display("FAIL t5_hold_s[%0d]: got %h expected 3333", i, bus.s); end
         checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t5_hold_flags[%0d]: got %b expected 000", i, {bus.co, bus.ovf, bus.z}); end
         checks++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin errors++; $display("FAIL t5_hold_hs[%0d]: got %b expected 01", i, {bus.in_ready, bus.out_valid}); end
      end
      // Next operation already requested while the result is consumed.
      bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.ci = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL t5_release_hs: got %b expected 10", {bus.in_ready, bus.out_valid}); end
      checks++; if (bus.s !== 16'h3333) begin errors++; $display("FAIL t5_release_s: got %h expected 3333", bus.s); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_done(lat);
      checks++; if (lat !== 4)          begin errors++; $display("FAIL t5_queued_latency: got %0d expected 4", lat); end
      checks++; if (bus.s !== 16'h1000) begin errors++; $display("FAIL t5_queued_s: got %h expected 1000", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t5_queued_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      finish_op();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      start_op(16'hFFFF, 16'h1234, 1'b1, 1'b1);
      @(posedge clk);
      @(posedge clk); #1;
      checks++; if (st !== 2'd1) begin errors++; $display("FAIL t6_pre_state: got %0d expected 1", st); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL t6_rst_hs: got %b expected 10", {bus.in_ready, bus.out_valid}); end
      checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL t6_rst_s: got %h expected 0000", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t6_rst_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_no_valid: got %b expected 0", bus.out_valid); end
      start_op(16'h0010, 16'h0001, 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 4)          begin errors++; $display("FAIL t6_latency: got %0d expected 4", lat); end
      checks++; if (bus.s !== 16'h000F) begin errors++; $display("FAIL t6_s: got %h expected 000f", bus.s); end
      checks++; if ({bus.co, bus.ovf, bus.z} !== 3'b000) begin errors++; $display("FAIL t6_flags: got %b expected 000", {bus.co, bus.ovf, bus.z}); end
      finish_op();
   endtask

   task automatic test_sweep();
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rci;
      logic        rmode;
      logic [15:0] e16_s;
      logic [15:0] e8_s;
      logic        e16_co, e16_ovf, e16_z;
      logic        e8_co, e8_ovf, e8_z;
      int          lat_m, lat_1, lat_16, lat_8;
      for (int it = 0; it < 16; it++) begin
         ra    = 16'($urandom_range(65535, 0));
         rb    = 16'($urandom_range(65535, 0));
         rci   = 1'($urandom_range(1, 0));
         rmode = 1'($urandom_range(1, 0));
         if (it == 0) begin ra = 16'hFFFF; rb = 16'h0000; rci = 1'b1; rmode = 1'b0; end
         if (it == 1) begin ra = 16'h0000; rb = 16'hFFFF; rci = 1'b1; rmode = 1'b1; end
         ref_model(16, ra, rb, rci, rmode, e16_s, e16_co, e16_ovf, e16_z);
         ref_model(8,  ra, rb, rci, rmode, e8_s,  e8_co,  e8_ovf,  e8_z);
         checks++;
         if ({bus.in_ready, bus_c1.in_ready, bus_c16.in_ready, bus_w8.in_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL sw_ready[%0d]: got %b expected 1111", it,
                     {bus.in_ready, bus_c1.in_ready, bus_c16.in_ready, bus_w8.in_ready});
         end
         bus.a = ra;     bus.b = rb;     bus.ci = rci;     bus.mode = rmode;
         bus_c1.a = ra;  bus_c1.b = rb;  bus_c1.ci = rci;  bus_c1.mode = rmode;
         bus_c16.a = ra; bus_c16.b = rb; bus_c16.ci = rci; bus_c16.mode = rmode;
         bus_w8.a = ra[7:0]; bus_w8.b = rb[7:0]; bus_w8.ci = rci; bus_w8.mode = rmode;
         bus.in_valid = 1'b1; bus_c1.in_valid = 1'b1; bus_c16.in_valid = 1'b1; bus_w8.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0; bus_c1.in_valid = 1'b0; bus_c16.in_valid = 1'b0; bus_w8.in_valid = 1'b0;
         lat_m = -1; lat_1 = -1; lat_16 = -1; lat_8 = -1;
         for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (lat_m  < 0 && bus.out_valid)     lat_m  = c;
            if (lat_1  < 0 && bus_c1.out_valid)  lat_1  = c;
            if (lat_16 < 0 && bus_c16.out_valid) lat_16 = c;
            if (lat_8  < 0 && bus_w8.out_valid)  lat_8  = c;
            if (lat_m >= 0 && lat_1 >= 0 && lat_16 >= 0 && lat_8 >= 0) break;
         end
         checks++; if (lat_m  !== 4)  begin errors++; $display("FAIL sw_lat_c4[%0d]: got %0d expected 4", it, lat_m); end
         checks++; if (lat_1  !== 16) begin errors++; $display("FAIL sw_lat_c1[%0d]: got %0d expected 16", it, lat_1); end
         checks++; if (lat_16 !== 1)  begin errors++; $display("FAIL sw_lat_c16[%0d]: got %0d expected 1", it, lat_16); end
         checks++; if (lat_8  !== 4)  begin errors++; $display("FAIL sw_lat_w8[%0d]: got %0d expected 4", it, lat_8); end
         checks++;
         if ({bus.s, bus.co, bus.ovf, bus.z} !== {e16_s, e16_co, e16_ovf, e16_z}) begin
            errors++;
            $display("FAIL sw_c4[%0d]: a=%h b=%h ci=%b m=%b got s=%h co=%b ovf=%b z=%b expected s=%h co=%b ovf=%b z=%b",
                     it, ra, rb, rci, rmode, bus.s, bus.co, bus.ovf, bus.z, e16_s, e16_co, e16_ovf, e16_z);
         end
         checks++;
         if ({bus_c1.s, bus_c1.co, bus_c1.ovf, bus_c1.z} !== {e16_s, e16_co, e16_ovf, e16_z}) begin
            errors++;
            $display("FAIL sw_c1[%0d]: a=%h b=%h ci=%b m=%b got s=%h co=%b ovf=%b z=%b expected s=%h co=%b ovf=%b z=%b",
                     it, ra, rb, rci, rmode, bus_c1.s, bus_c1.co, bus_c1.ovf, bus_c1.z, e16_s, e16_co, e16_ovf, e16_z);
         end
         checks++;
         if ({bus_c16.s, bus_c16.co, bus_c16.ovf, bus_c16.z} !== {e16_s, e16_co, e16_ovf, e16_z}) begin
            errors++;
            $display("FAIL sw_c16[%0d]: a=%h b=%h ci=%b m=%b got s=%h co=%b ovf=%b z=%b expected s=%h co=%b ovf=%b z=%b",
                     it, ra, rb, rci, rmode, bus_c16.s, bus_c16.co, bus_c16.ovf, bus_c16.z, e16_s, e16_co, e16_ovf, e16_z);
         end
         checks++;
         if ({bus_w8.s, bus_w8.co, bus_w8.ovf, bus_w8.z} !== {e8_s[7:0], e8_co, e8_ovf, e8_z}) begin
            errors++;
            $display("FAIL sw_w8[%0d]: a=%h b=%h ci=%b m=%b got s=%h co=%b ovf=%b z=%b expected s=%h co=%b ovf=%b z=%b",
                     it, ra[7:0], rb[7:0], rci, rmode, bus_w8.s, bus_w8.co, bus_w8.ovf, bus_w8.z, e8_s[7:0], e8_co, e8_ovf, e8_z);
         end
         bus.out_ready = 1'b1; bus_c1.out_ready = 1'b1; bus_c16.out_ready = 1'b1; bus_w8.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0; bus_c1.out_ready = 1'b0; bus_c16.out_ready = 1'b0; bus_w8.out_ready = 1'b0;
      end
   endtask

   // Test sequence
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.in_valid = 1'b0;     bus.out_ready = 1'b0;     bus.a = '0;     bus.b = '0;     bus.ci = 1'b0;     bus.mode = 1'b0;
      bus_c1.in_valid = 1'b0;  bus_c1.out_ready = 1'b0;  bus_c1.a = '0;  bus_c1.b = '0;  bus_c1.ci = 1'b0;  bus_c1.mode = 1'b0;
      bus_c16.in_valid = 1'b0; bus_c16.out_ready = 1'b0; bus_c16.a = '0; bus_c16.b = '0; bus_c16.ci = 1'b0; bus_c16.mode = 1'b0;
      bus_w8.in_valid = 1'b0;  bus_w8.out_ready = 1'b0;  bus_w8.a = '0;  bus_w8.b = '0;  bus_w8.ci = 1'b0;  bus_w8.mode = 1'b0;
      test_reset();
      test_subtract();
      test_underflow();
      test_overflow();
      test_carry_wrap();
      test_backpressure();
      test_reset_mid_run();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, chaining carry or borrow between chunks through a register. Operands are accepted on a valid/ready input handshake, and the result is presented on a valid/ready output handshake. It is the sequential, mode-selectable, width-generic successor to the team's combinational ripple subtractors, intended for datapaths where area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits processed per RUN cycle; NCHUNK = WIDTH/CHUNK
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend / augend
- b  in  WIDTH  subtrahend / addend
- ci  in  1  carry-in (add) or borrow-in (sub)
- mode  in  1  0 = add (a+b+ci), 1 = subtract (a-b-ci)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum / difference
- co  out  1  carry-out (add) or borrow-out (sub; 1 when a < b+ci unsigned)
- ovf  out  1  two's-complement overflow
- z  out  1  s == 0

## Operation
- Reset is asynchronous and active-low, with one clock. While rst_n=0 and after release:
  - state is IDLE
  - in_ready=1, out_valid=0
  - s=0, co=0, ovf=0, z=0
  - internal operand, result and carry registers are cleared
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, ci and mode into working registers, set the chunk counter to 0, preload the chain register with ci, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, compute chunk k = counter from the low CHUNK bits of the shifted operand registers.
  - Add: {c, r} = a_k + b_k + chain.
  - Sub: r = a_k - b_k - chain, with borrow c = 1 when a_k < b_k + chain (unsigned, CHUNK+1-bit compare).
  - Shift r into the result register from the top, shift the operands right by CHUNK, store c in the chain register, and increment the counter.
  - After the cycle that processes chunk NCHUNK-1, go to DONE.
- Output registers (s, co, ovf, z) load on the edge entering DONE:
  - s = assembled result; co = final chain.
  - ovf for add: (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
  - ovf for sub: (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
  - z = (s==0).
- DONE:
  - out_valid=1, in_ready=0. Outputs are held stable.
  - On out_ready, go to IDLE.
- s, co, ovf and z keep their last DONE values through the following IDLE and RUN phases. They change only on DONE entry or reset.
- in_valid is ignored outside IDLE. Operand changes after acceptance have no effect on the operation in flight.
- mode and ci are sampled only at acceptance.
- All arithmetic is modulo 2^WIDTH. No internal width growth is visible except co.

## Timing
- Input accepted at edge E: RUN occupies edges E+1 … E+NCHUNK, and out_valid=1 after edge E+NCHUNK.
- Output handshake at edge F: out_valid=0 and in_ready=1 after F. The earliest next acceptance is edge F+1.
- Minimum issue interval with out_ready tied high: NCHUNK+2 cycles.
- Degenerate case CHUNK==WIDTH: a single RUN cycle, and the result is valid 1 cycle after acceptance.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. Outputs go to reset values, no out_valid is produced, and the first operation after release is unaffected.
- out_ready asserted while not in DONE has no effect.

## Test plan
Tests 1–6 use WIDTH=16 and CHUNK=4.
1. Subtract, a=0x1234, b=0x0235, ci=0, mode=1 -> s=0x0FFF, co=0, ovf=0, z=0. out_valid rises exactly 4 cycles after acceptance.
2. Subtract underflow, a=0x0000, b=0x0001, ci=0 -> s=0xFFFF, co=1, ovf=0. Separately, a=0x0005, b=0x0005, ci=1 -> s=0xFFFF, co=1.
3. Signed overflow:
   - Add 0x7FFF+0x0001, ci=0 -> s=0x8000, co=0, ovf=1.
   - Sub 0x8000-0x0001 -> s=0x7FFF, co=0, ovf=1.
4. Carry wrap, add 0xFFFF+0x0001, ci=0 -> s=0x0000, co=1, z=1, ovf=0. Then add 0x00FF+0x0000 with ci=1 -> s=0x0100, co=0, z=0.
5. Backpressure:
   - Hold out_ready=0 for 10 cycles in DONE: s, co, ovf and z stay stable, in_ready=0, and a toggling in_valid with new operands is ignored.
   - Raise out_ready: the next cycle has in_ready=1, and the queued operation then completes correctly.
6. Reset mid-operation: drop rst_n after 2 RUN cycles. Immediately in_ready=1, out_valid=0 and all outputs are 0. After release, sub 0x0010-0x0001 -> s=0x000F.
7. Parameter sweep with random operands, CHUNK ∈ {1, 4, 16} and WIDTH=16, plus WIDTH=8/CHUNK=2, against a behavioural reference: all fields match, and latency equals NCHUNK.
